// File: rtl/commit_trace_fifo.sv
// Commit-trace recorder: classifies, numbers and buffers retired-instruction
// records in a DEPTH-entry FIFO drained over a valid/ready port.
module commit_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [DATA_W-1:0] commit_pc,
    input  logic [DATA_W-1:0] commit_inst,
    input  logic              reg_write,
    input  logic [2:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [CNT_W-1:0]  out_inum,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic [2:0]        out_reg,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_mdata,
    output logic [CNT_W-1:0]  out_cycle,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              halted,
    output logic              drained
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [AW:0] PTR_ONE = 1;

    typedef struct packed {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic [2:0]        rd;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] mdata;
        logic [CNT_W-1:0]  cycle;
    } rec_t;

    rec_t mem [DEPTH];
    rec_t new_rec;
    rec_t head;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        accept;
    logic        pop;
    logic        push;
    logic [2:0]  kind;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign accept = commit_valid && !halted && !rst;
    assign pop    = !empty && out_ready;
    // A full FIFO can still take a record when its head leaves this cycle.
    assign push   = accept && (!full || pop);

    // Record classification, halt taking precedence over everything.
    always_comb begin
        kind = 3'd5;
        if (halt)
            kind = 3'd4;
        else if (reg_write && mem_write)
            kind = 3'd3;
        else if (reg_write && mem_read)
            kind = 3'd1;
        else if (reg_write)
            kind = 3'd0;
        else if (mem_write)
            kind = 3'd2;
    end

    // Assemble the record being captured this cycle.
    always_comb begin
        new_rec.kind  = kind;
        new_rec.inum  = inst_count;
        new_rec.pc    = commit_pc;
        new_rec.inst  = commit_inst;
        new_rec.rd    = write_reg;
        new_rec.rdata = write_data;
        new_rec.addr  = mem_addr;
        new_rec.mdata = mem_data;
        new_rec.cycle = cycle_count;
    end

    // Storage array; contents are masked at the output while empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= new_rec;
    end

    // Pointers, counters and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            inst_count  <= '0;
            cycle_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (accept)
                inst_count <= inst_count + CNT_ONE;
            if (accept && !push) begin
                drop_count <= drop_count + CNT_ONE;
                overflow   <= 1'b1;
            end
            if (accept && halt)
                halted <= 1'b1;
            if (!halted)
                cycle_count <= cycle_count + CNT_ONE;
        end
    end

    // Head presentation, zeroed while the FIFO is empty.
    always_comb begin
        head = '0;
        if (!empty)
            head = mem[rd_ptr[AW-1:0]];
    end

    assign out_valid = !empty;
    assign out_kind  = head.kind;
    assign out_inum  = head.inum;
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign out_reg   = head.rd;
    assign out_rdata = head.rdata;
    assign out_addr  = head.addr;
    assign out_mdata = head.mdata;
    assign out_cycle = head.cycle;
    assign drained   = halted && empty;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Testbench for commit_trace_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_commit_trace_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [15:0] commit_pc;
    logic [15:0] commit_inst;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_kind;
    logic [31:0] out_inum;
    logic [15:0] out_pc;
    logic [15:0] out_inst;
    logic [2:0]  out_reg;
    logic [15:0] out_rdata;
    logic [15:0] out_addr;
    logic [15:0] out_mdata;
    logic [31:0] out_cycle;
    logic [31:0] inst_count;
    logic [31:0] cycle_count;
    logic [31:0] drop_count;
    logic        overflow;
    logic        halted;
    logic        drained;

    commit_trace_fifo #(.DEPTH(DEPTH), .DATA_W(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_inst(commit_inst),
        .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .halt(halt), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind),
        .out_inum(out_inum), .out_pc(out_pc), .out_inst(out_inst),
        .out_reg(out_reg), .out_rdata(out_rdata),
        .out_addr(out_addr), .out_mdata(out_mdata),
        .out_cycle(out_cycle), .inst_count(inst_count),
        .cycle_count(cycle_count), .drop_count(drop_count),
        .overflow(overflow), .halted(halted), .drained(drained)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [2:0]  rg;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic [31:0] cyc;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_ic = 0;
    logic [31:0] m_cc = 0;
    logic [31:0] m_dc = 0;
    logic        m_ov = 0;
    logic        m_hl = 0;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [2:0] kind_of(logic h, logic rw,
                                           logic mr, logic mw);
        if (h) return 3'd4;
        if (rw && mw) return 3'd3;
        if (rw && mr) return 3'd1;
        if (rw) return 3'd0;
        if (mw) return 3'd2;
        return 3'd5;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        rec_t h;
        h = '{default: '0};
        if (q.size() != 0) h = q[0];
        chk("out_valid", 160'(out_valid), 160'(q.size() != 0));
        chk("head",
            {out_kind, out_inum, out_pc, out_inst, out_reg,
             out_rdata, out_addr, out_mdata, out_cycle},
            {h.kind, h.inum, h.pc, h.inst, h.rg,
             h.rdata, h.addr, h.mdata, h.cyc});
        chk("counters", {inst_count, cycle_count, drop_count},
            {m_ic, m_cc, m_dc});
        chk("flags", {overflow, halted, drained},
            {m_ov, m_hl, m_hl && q.size() == 0});
    endtask

    task automatic model_update();
        rec_t r;
        bit   pop;
        bit   acc;
        if (rst) begin
            q.delete();
            m_ic = 0; m_cc = 0; m_dc = 0; m_ov = 0; m_hl = 0;
            return;
        end
        pop = out_ready && q.size() != 0;
        acc = commit_valid && !m_hl;
        if (pop) void'(q.pop_front());
        if (acc) begin
            r.kind = kind_of(halt, reg_write, mem_read, mem_write);
            r.inum = m_ic; r.pc = commit_pc; r.inst = commit_inst;
            r.rg = write_reg; r.rdata = write_data; r.addr = mem_addr;
            r.mdata = mem_data; r.cyc = m_cc;
            m_ic++;
            if (q.size() < DEPTH) q.push_back(r);
            else begin m_dc++; m_ov = 1; end
        end
        if (!m_hl) m_cc++;
        if (acc && halt) m_hl = 1;
    endtask

    task automatic step();
        check_outputs();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_fields();
        commit_pc   = 16'($urandom);
        commit_inst = 16'($urandom);
        write_reg   = 3'($urandom);
        write_data  = 16'($urandom);
        mem_addr    = 16'($urandom);
        mem_data    = 16'($urandom);
    endtask

    task automatic rand_ctl();
        reg_write = 1'($urandom);
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
    endtask

    logic [31:0] dc0;
    logic [31:0] fc;

    initial begin
        rst = 1; commit_valid = 0; out_ready = 0; halt = 0;
        reg_write = 0; mem_read = 0; mem_write = 0;
        commit_pc = 0; commit_inst = 0; write_reg = 0;
        write_data = 0; mem_addr = 0; mem_data = 0;
        @(posedge clk);
        @(negedge clk);
        step();
        rst = 0;
        chk("rst_valid", 160'(out_valid), 160'(0));
        chk("rst_cnt", {inst_count, cycle_count, drop_count}, 160'(0));
        chk("rst_head", {out_kind, out_inum, out_rdata}, 160'(0));

        // 1. single ALU commit
        commit_valid = 1; commit_pc = 16'h0002; reg_write = 1;
        write_reg = 3; write_data = 16'h00AB;
        step();
        commit_valid = 0;
        chk("t1_valid", 160'(out_valid), 160'(1));
        chk("t1_kind", 160'(out_kind), 160'(0));
        chk("t1_inum", 160'(out_inum), 160'(0));
        chk("t1_rdata", 160'(out_rdata), 160'(16'h00AB));
        out_ready = 1;
        step();

        // 2. overflow by one, then drain in order
        rst = 1; step(); rst = 0;
        out_ready = 0; commit_valid = 1;
        for (int i = 0; i < 17; i++) begin
            rand_fields(); rand_ctl(); step();
        end
        commit_valid = 0;
        chk("t2_drop", 160'(drop_count), 160'(1));
        chk("t2_ovf", 160'(overflow), 160'(1));
        chk("t2_icnt", 160'(inst_count), 160'(17));
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_inum", 160'(out_inum), 160'(i));
            step();
        end
        step();

        // 3. full FIFO with simultaneous push and pop
        out_ready = 0; commit_valid = 1;
        for (int i = 0; i < 16; i++) begin
            rand_fields(); rand_ctl(); step();
        end
        dc0 = m_dc;
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            rand_fields(); rand_ctl(); step();
            chk("t3_valid", 160'(out_valid), 160'(1));
        end
        chk("t3_drop", 160'(drop_count), 160'(dc0));
        commit_valid = 0;
        for (int i = 0; i < 18; i++) step();

        // 4. kind classification
        out_ready = 0; commit_valid = 1; rand_fields();
        reg_write = 1; mem_write = 1; mem_read = 0;
        mem_addr = 16'h0100; mem_data = 16'h1234;
        step();
        commit_valid = 0; out_ready = 1;
        chk("t4_stu", {out_kind, out_addr, out_mdata},
            {3'd3, 16'h0100, 16'h1234});
        commit_valid = 1; rand_fields();
        reg_write = 1; mem_write = 0; mem_read = 1;
        step();
        chk("t4_load", 160'(out_kind), 160'(1));
        reg_write = 0; mem_write = 0; mem_read = 0;
        step();
        chk("t4_nop", 160'(out_kind), 160'(5));
        commit_valid = 0;
        step();

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            commit_valid = ($urandom_range(0, 3) != 0);
            out_ready = (i < 200) ? ($urandom_range(0, 2) == 0)
                                  : ($urandom_range(0, 3) != 0);
            rand_fields(); rand_ctl();
            step();
        end
        rst = 0;

        // 5. halt at inst 5
        rst = 1; step(); rst = 0;
        out_ready = 1; commit_valid = 1;
        for (int i = 0; i < 5; i++) begin
            rand_fields(); rand_ctl(); step();
        end
        halt = 1; rand_fields(); step(); halt = 0;
        chk("t5_halted", 160'(halted), 160'(1));
        chk("t5_kind", 160'(out_kind), 160'(4));
        chk("t5_inum", 160'(out_inum), 160'(5));
        fc = cycle_count;
        for (int i = 0; i < 3; i++) begin
            rand_fields(); rand_ctl(); step();
        end
        chk("t5_frozen", 160'(cycle_count), 160'(fc));
        chk("t5_icnt", 160'(inst_count), 160'(6));
        chk("t5_drained", 160'(drained), 160'(1));

        // 6. reset mid-operation
        rst = 1; step(); rst = 0;
        out_ready = 0; commit_valid = 1;
        for (int i = 0; i < 17; i++) begin
            rand_fields(); rand_ctl(); step();
        end
        commit_valid = 0; out_ready = 1;
        for (int i = 0; i < 8; i++) step();
        chk("t6_ovf_pre", 160'(overflow), 160'(1));
        rst = 1; commit_valid = 1; out_ready = 0; step();
        rst = 0; commit_valid = 0;
        chk("t6_valid", 160'(out_valid), 160'(0));
        chk("t6_ovf", 160'(overflow), 160'(0));
        chk("t6_cnt", {inst_count, drop_count}, 160'(0));
        chk("t6_cyc", 160'(cycle_count), 160'(0));
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
